// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator sequencing controller.
package calc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_OPA,
      ST_OPW,
      ST_OPB,
      ST_EXEC,
      ST_WAIT_ALU,
      ST_SEND,
      ST_RESULT,
      ST_ERROR
   } state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_ISSUE,
      TX_ACK,
      TX_DRAIN
   } tx_phase_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   localparam logic [3:0] KEY_ENTER = 4'hE;
   localparam logic [3:0] KEY_CLEAR = 4'hF;

endpackage

// File: rtl/calc_tx_seq.sv
// Result transmitter sequencer: sends value as hex nibbles, MSB first, one
// tx_start per nibble with an ISSUE/ACK/DRAIN handshake against tx_busy.
module calc_tx_seq
   import calc_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         go,
   input  logic [W-1:0] value,
   input  logic         abort,
   input  logic         tx_busy,
   output logic         tx_start,
   output logic [3:0]   tx_data,
   output logic         done
);

   localparam int unsigned NIB = W / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

   tx_phase_t       r_phase;
   tx_phase_t       w_phase_nx;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_idx_nx;

   // Phase and nibble-index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= TX_IDLE;
         r_idx   <= '0;
      end else begin
         r_phase <= w_phase_nx;
         r_idx   <= w_idx_nx;
      end
   end

   // Handshake progression; abort returns to idle regardless of the link.
   always_comb begin
      w_phase_nx = r_phase;
      w_idx_nx   = r_idx;
      if (abort) begin
         w_phase_nx = TX_IDLE;
         w_idx_nx   = '0;
      end else begin
         case (r_phase)
            TX_IDLE: begin
               if (go) begin
                  w_phase_nx = TX_ISSUE;
                  w_idx_nx   = IW'(NIB - 1);
               end
            end
            TX_ISSUE: if (!tx_busy) w_phase_nx = TX_ACK;
            TX_ACK:   if (tx_busy)  w_phase_nx = TX_DRAIN;
            TX_DRAIN: begin
               if (!tx_busy) begin
                  if (r_idx == '0) begin
                     w_phase_nx = TX_IDLE;
                  end else begin
                     w_idx_nx   = r_idx - IW'(1);
                     w_phase_nx = TX_ISSUE;
                  end
               end
            end
            default: w_phase_nx = TX_IDLE;
         endcase
      end
   end

   // Start pulse is gated by tx_busy so it can never fire into a busy link.
   always_comb begin
      tx_start = (r_phase == TX_ISSUE) && !tx_busy && !abort;
      tx_data  = 4'(value >> {r_idx, 2'b00});
      done     = (r_phase == TX_DRAIN) && !tx_busy && (r_idx == '0) && !abort;
   end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator key sequencer: assembles operand A, operator, operand B from
// decoded key pulses, runs the ALU handshake and streams the result out.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned W      = 16,
   parameter int unsigned MAXDIG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx_valid,
   input  logic [3:0]   rx_data,
   input  logic         is_digit,
   input  logic         is_operator,
   input  logic         is_enter,
   input  logic         is_clear,
   output logic         alu_start,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic         alu_done,
   input  logic [W-1:0] alu_result,
   input  logic         alu_err,
   output logic         tx_start,
   output logic [3:0]   tx_data,
   input  logic         tx_busy,
   output logic         busy,
   output logic         err
);

   localparam int unsigned CW = $clog2(MAXDIG + 1);

   state_t          r_state;
   state_t          w_state_nx;
   logic [W-1:0]    r_acc_a;
   logic [W-1:0]    r_acc_b;
   logic [1:0]      r_op;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_alu_a;
   logic [W-1:0]    r_alu_b;
   logic [1:0]      r_alu_op;

   logic            w_clear;
   logic            w_digit;
   logic            w_oper;
   logic            w_enter;
   logic            w_room;
   logic [W-1:0]    w_dig;
   logic [W-1:0]    w_mac_a;
   logic [W-1:0]    w_mac_b;
   logic [1:0]      w_key_op;
   logic            w_go;
   logic            w_tx_done;

   assign w_clear  = rx_valid && is_clear;
   assign w_digit  = rx_valid && is_digit;
   assign w_oper   = rx_valid && is_operator;
   assign w_enter  = rx_valid && is_enter;
   assign w_room   = r_cnt < CW'(MAXDIG);
   assign w_dig    = W'(rx_data);
   assign w_mac_a  = (r_acc_a << 3) + (r_acc_a << 1) + w_dig;
   assign w_mac_b  = (r_acc_b << 3) + (r_acc_b << 1) + w_dig;
   // Operator keys A..D map onto add/sub/mul/div in key order.
   assign w_key_op = 2'(rx_data - 4'hA);
   assign w_go     = (r_state == ST_WAIT_ALU) && alu_done && !alu_err && !w_clear;

   calc_tx_seq #(.W(W)) u_tx_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (w_go),
      .value    (r_acc_a),
      .abort    (w_clear),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .done     (w_tx_done)
   );

   // Key FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   // Key FSM transitions; Clear overrides everything, including alu_done.
   always_comb begin
      w_state_nx = r_state;
      if (w_clear) begin
         w_state_nx = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:     if (w_digit) w_state_nx = ST_OPA;
            ST_OPA:      if (w_oper)  w_state_nx = ST_OPW;
            ST_OPW:      if (w_digit) w_state_nx = ST_OPB;
            ST_OPB:      if (w_enter) w_state_nx = ST_EXEC;
            ST_EXEC:     w_state_nx = ST_WAIT_ALU;
            ST_WAIT_ALU: if (alu_done) w_state_nx = alu_err ? ST_ERROR : ST_SEND;
            ST_SEND:     if (w_tx_done) w_state_nx = ST_RESULT;
            ST_RESULT: begin
               if (w_oper)       w_state_nx = ST_OPW;
               else if (w_digit) w_state_nx = ST_OPA;
            end
            ST_ERROR:    w_state_nx = ST_ERROR;
            default:     w_state_nx = ST_IDLE;
         endcase
      end
   end

   // State-decoded outputs.
   always_comb begin
      alu_start = (r_state == ST_EXEC);
      busy      = (r_state == ST_EXEC) || (r_state == ST_WAIT_ALU) || (r_state == ST_SEND);
      err       = (r_state == ST_ERROR);
   end

   // Operand accumulators, operator, digit count and the ALU operand registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_a  <= '0;
         r_acc_b  <= '0;
         r_op     <= OP_ADD;
         r_cnt    <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= OP_ADD;
      end else if (w_clear) begin
         r_acc_a <= '0;
         r_acc_b <= '0;
         r_op    <= OP_ADD;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_RESULT: begin
               if (w_digit) begin
                  r_acc_a <= w_dig;
                  r_cnt   <= CW'(1);
               end else if (w_oper && (r_state == ST_RESULT)) begin
                  r_op <= w_key_op;
               end
            end
            ST_OPA: begin
               if (w_digit && w_room) begin
                  r_acc_a <= w_mac_a;
                  r_cnt   <= r_cnt + CW'(1);
               end else if (w_oper) begin
                  r_op <= w_key_op;
               end
            end
            ST_OPW: begin
               if (w_oper) begin
                  r_op <= w_key_op;
               end else if (w_digit) begin
                  r_acc_b <= w_dig;
                  r_cnt   <= CW'(1);
               end
            end
            ST_OPB: begin
               if (w_digit && w_room) begin
                  r_acc_b <= w_mac_b;
                  r_cnt   <= r_cnt + CW'(1);
               end else if (w_enter) begin
                  r_alu_a  <= r_acc_a;
                  r_alu_b  <= r_acc_b;
                  r_alu_op <= r_op;
               end
            end
            ST_WAIT_ALU: begin
               if (alu_done && !alu_err) r_acc_a <= alu_result;
            end
            default: ;
         endcase
      end
   end

   assign alu_a  = r_alu_a;
   assign alu_b  = r_alu_b;
   assign alu_op = r_alu_op;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: scoreboard queues of expected ALU
// launches and transmitted nibbles, with a simple transmitter busy model.
module tb_calc_ctrl;
   import calc_pkg::*;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
   } alu_txn_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx_valid = 1'b0;
   logic [3:0]   rx_data = '0;
   logic         is_digit = 1'b0;
   logic         is_operator = 1'b0;
   logic         is_enter = 1'b0;
   logic         is_clear = 1'b0;
   logic         alu_start;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_op;
   logic         alu_done = 1'b0;
   logic [W-1:0] alu_result = '0;
   logic         alu_err = 1'b0;
   logic         tx_start;
   logic [3:0]   tx_data;
   logic         tx_busy = 1'b0;
   logic         busy;
   logic         err;

   alu_txn_t     exp_alu[$];
   logic [3:0]   exp_nib[$];
   alu_txn_t     last_txn = '0;
   int           n_chk = 0;
   int           n_err = 0;
   int           alu_starts = 0;
   int           tx_starts = 0;

   calc_ctrl #(.W(W), .MAXDIG(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .is_digit    (is_digit),
      .is_operator (is_operator),
      .is_enter    (is_enter),
      .is_clear    (is_clear),
      .alu_start   (alu_start),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .alu_err     (alu_err),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: pop and compare whenever the DUT launches or transmits.
   always @(negedge clk) begin
      if (alu_start) begin
         alu_txn_t t;
         alu_starts++;
         chk("alu_expected", 32'(exp_alu.size() != 0), 1);
         if (exp_alu.size() != 0) begin
            t = exp_alu.pop_front();
            last_txn = t;
            chk("alu_a", 32'(alu_a), 32'(t.a));
            chk("alu_b", 32'(alu_b), 32'(t.b));
            chk("alu_op", 32'(alu_op), 32'(t.op));
         end
      end
      if (tx_start) begin
         tx_starts++;
         chk("tx_while_busy", 32'(tx_busy), 0);
         chk("tx_expected", 32'(exp_nib.size() != 0), 1);
         if (exp_nib.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_nib.pop_front()));
      end
   end

   // Transmitter model: busy rises the cycle after tx_start, holds a few cycles.
   initial begin
      logic l_go;
      int   busy_cnt;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         l_go = tx_start;
         @(posedge clk);
         #1;
         if (l_go) begin
            tx_busy  = 1'b1;
            busy_cnt = 3;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] k);
      rx_valid    = 1'b1;
      rx_data     = k;
      is_digit    = (k <= 4'd9);
      is_operator = (k >= 4'hA) && (k <= 4'hD);
      is_enter    = (k == KEY_ENTER);
      is_clear    = (k == KEY_CLEAR);
      tick(1);
      rx_valid    = 1'b0;
      rx_data     = '0;
      is_digit    = 1'b0;
      is_operator = 1'b0;
      is_enter    = 1'b0;
      is_clear    = 1'b0;
   endtask

   task automatic keys(input string s);
      for (int i = 0; i < s.len(); i++) begin
         byte c;
         c = s[i];
         if (c <= 8'h39) press(4'(c - 8'h30));
         else            press(4'(c - 8'h37));
      end
   endtask

   task automatic push_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      alu_txn_t t;
      t.a  = a;
      t.b  = b;
      t.op = op;
      exp_alu.push_back(t);
   endtask

   task automatic push_nibs(input logic [W-1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         logic [W-1:0] sh;
         sh = v >> (4 * (W / 4 - 1 - i));
         exp_nib.push_back(sh[3:0]);
      end
   endtask

   // Called right after the Enter key: launch must be high now and for one cycle only.
   task automatic check_launch(input string tag);
      chk({tag, "_start"}, 32'(alu_start), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      tick(1);
      chk({tag, "_pulse"}, 32'(alu_start), 0);
   endtask

   task automatic respond(input logic [W-1:0] res, input logic e, input int dly);
      tick(dly);
      alu_done   = 1'b1;
      alu_result = res;
      alu_err    = e;
      @(negedge clk);
      chk("hold_a", 32'(alu_a), 32'(last_txn.a));
      chk("hold_b", 32'(alu_b), 32'(last_txn.b));
      chk("hold_op", 32'(alu_op), 32'(last_txn.op));
      @(posedge clk);
      #1;
      alu_done   = 1'b0;
      alu_err    = 1'b0;
      alu_result = '0;
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while (busy && g < 300) begin
         tick(1);
         g++;
      end
      chk({tag, "_idle"}, 32'(busy), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_nib_left"}, 32'(exp_nib.size()), 0);
   endtask

   task automatic wait_tx(input int target);
      int g;
      g = 0;
      while (tx_starts < target && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("tx_wait", 32'(tx_starts >= target), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      tick(1);
      chk("rst_alu_start", 32'(alu_start), 0);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      chk("rst_alu_b", 32'(alu_b), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // 12 + 3 = 15
      push_alu(16'd12, 16'd3, OP_ADD);
      keys("12A3E");
      check_launch("add");
      push_nibs(16'h000F, 4);
      respond(16'd15, 1'b0, 3);
      wait_idle("add");
      chk("add_tx_count", 32'(tx_starts), 4);

      // Chained: 15 - 5
      push_alu(16'd15, 16'd5, OP_SUB);
      keys("B5E");
      check_launch("chain");
      push_nibs(16'd10, 4);
      respond(16'd10, 1'b0, 2);
      wait_idle("chain");

      // Fifth digit dropped: 9999 * 2
      push_alu(16'd9999, 16'd2, OP_MUL);
      keys("F99999C2E");
      check_launch("maxdig");
      push_nibs(16'd19998, 4);
      respond(16'd19998, 1'b0, 1);
      wait_idle("maxdig");

      // Digit in RESULT starts a fresh calculation
      push_alu(16'd7, 16'd1, OP_ADD);
      keys("7A1E");
      check_launch("fresh");
      push_nibs(16'd8, 4);
      respond(16'd8, 1'b0, 1);
      wait_idle("fresh");

      // Divide by zero -> ERROR, keys ignored until Clear
      push_alu(16'd8, 16'd0, OP_DIV);
      keys("F8D0E");
      check_launch("div0");
      base = tx_starts;
      respond(16'd0, 1'b1, 2);
      chk("div0_err", 32'(err), 1);
      chk("div0_busy", 32'(busy), 0);
      keys("55A");
      tick(5);
      chk("div0_err_hold", 32'(err), 1);
      chk("div0_no_tx", 32'(tx_starts), 32'(base));
      keys("F");
      chk("div0_clr_err", 32'(err), 0);
      chk("div0_clr_busy", 32'(busy), 0);
      push_alu(16'd2, 16'd2, OP_ADD);
      keys("2A2E");
      check_launch("after_clr");
      push_nibs(16'd4, 4);
      respond(16'd4, 1'b0, 1);
      wait_idle("after_clr");

      // Clear during SEND after two nibbles
      push_alu(16'd1, 16'd1, OP_ADD);
      keys("1A1E");
      check_launch("send_clr");
      base = tx_starts;
      push_nibs(16'h1234, 2);
      respond(16'h1234, 1'b0, 1);
      wait_tx(base + 2);
      @(posedge clk);
      #1;
      keys("F");
      tick(20);
      chk("send_clr_tx", 32'(tx_starts), 32'(base + 2));
      chk("send_clr_busy", 32'(busy), 0);
      chk("send_clr_nib_left", 32'(exp_nib.size()), 0);
      // Operator is ignored in IDLE; a zeroed A is then overwritten by 3
      push_alu(16'd3, 16'd4, OP_SUB);
      keys("A3B4E");
      check_launch("post_send_clr");
      push_nibs(16'hFFFF, 4);
      respond(16'hFFFF, 1'b0, 1);
      wait_idle("post_send_clr");

      // Clear during WAIT_ALU; the late done must be ignored
      push_alu(16'd5, 16'd5, OP_ADD);
      keys("5A5E");
      check_launch("wait_clr");
      base = tx_starts;
      keys("F");
      chk("wait_clr_busy", 32'(busy), 0);
      respond(16'd10, 1'b0, 2);
      tick(10);
      chk("wait_clr_no_tx", 32'(tx_starts), 32'(base));
      chk("wait_clr_busy2", 32'(busy), 0);
      chk("wait_clr_err", 32'(err), 0);
      push_alu(16'd3, 16'd3, OP_ADD);
      keys("3A3E");
      check_launch("post_wait_clr");
      push_nibs(16'd6, 4);
      respond(16'd6, 1'b0, 1);
      wait_idle("post_wait_clr");

      // Asynchronous reset mid-SEND
      push_alu(16'd1, 16'd1, OP_ADD);
      keys("1A1E");
      check_launch("rst_send");
      base = tx_starts;
      push_nibs(16'hABCD, 1);
      respond(16'hABCD, 1'b0, 1);
      wait_tx(base + 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_tx_start", 32'(tx_start), 0);
      chk("arst_tx_data", 32'(tx_data), 0);
      chk("arst_alu_start", 32'(alu_start), 0);
      chk("arst_alu_a", 32'(alu_a), 0);
      chk("arst_alu_b", 32'(alu_b), 0);
      chk("arst_err", 32'(err), 0);
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("arst_no_tx", 32'(tx_starts), 32'(base + 1));
      chk("end_alu_left", 32'(exp_alu.size()), 0);
      chk("end_nib_left", 32'(exp_nib.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
